// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, key indices and default durations for the traffic controller
package traffic_pkg;
    typedef enum logic [2:0] {
        S_GREEN,
        S_YELLOW,
        S_ALL_RED,
        F_GREEN,
        F_RED,
        F_YELLOW,
        F_OFF
    } state_t;
    localparam int KEY_GREEN     = 0;
    localparam int KEY_RED       = 1;
    localparam int KEY_YELLOW    = 2;
    localparam int KEY_OFF       = 3;
    localparam int DEF_T_GREEN     = 30;
    localparam int DEF_T_YELLOW    = 5;
    localparam int DEF_T_ALLRED    = 2;
    localparam int DEF_T_MIN_GREEN = 8;
endpackage

// File: rtl/traffic_ctrl_multi_timer.sv
// traffic_timer: loadable down-counter stepped by the 1 Hz tick, with truncation and expiry detect
module traffic_timer #(
    parameter int               CNT_W   = 6,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             trunc,
    input  logic [CNT_W-1:0] trunc_val,
    output logic [CNT_W-1:0] timer,
    output logic             expire
);
    assign expire = tick && (timer <= CNT_W'(1));
    // load beats truncation, truncation beats the tick decrement
    always_ff @(posedge clk) begin
        if (rst)        timer <= RST_VAL;
        else if (load)  timer <= load_val;
        else if (trunc) timer <= trunc_val;
        else if (tick)  timer <= timer - CNT_W'(1);
    end
endmodule

// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: round-robin N-approach controller with key overrides and pedestrian truncation; TRAFFIC_FLASH_EN makes forced yellow flash
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int N_DIR       = 2,
    parameter int CNT_W       = 6,
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    localparam int AW         = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic [3:0]       key,
    input  logic [N_DIR-1:0] ped_req,
    output logic [N_DIR-1:0] red,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] green,
    output logic [AW-1:0]    active_dir,
    output logic [CNT_W-1:0] countdown,
    output logic             blank
);
    state_t           state, state_n;
    logic [AW-1:0]    dir_n;
    logic             adv, adv_n;
    logic [N_DIR-1:0] latch, pend, dir_mask, clr_mask;
    logic [CNT_W-1:0] timer, load_val;
    logic             load, trunc, expire, forced, yel_on;

    assign forced   = state inside {F_GREEN, F_RED, F_YELLOW, F_OFF};
    assign dir_mask = N_DIR'(1) << active_dir;
    assign pend     = latch | (ped_req & ~(state == S_GREEN ? dir_mask : '0));
    assign trunc    = state == S_GREEN && (&key) && |(pend & ~dir_mask) && timer > CNT_W'(T_MIN_GREEN);
    assign clr_mask = (state == S_ALL_RED && state_n == S_GREEN) ? N_DIR'(1) << dir_n : '0;

    traffic_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(T_ALLRED))) u_timer (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick_1hz),
        .load      (load),
        .load_val  (load_val),
        .trunc     (trunc),
        .trunc_val (CNT_W'(T_MIN_GREEN)),
        .timer     (timer),
        .expire    (expire)
    );

    // state, served approach, advance flag and pedestrian latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_ALL_RED;
            active_dir <= '0;
            adv        <= 1'b0;
            latch      <= '0;
        end else begin
            state      <= state_n;
            active_dir <= dir_n;
            adv        <= adv_n;
            latch      <= pend & ~clr_mask;
        end
    end

    // next state: keys by priority, then release to clearance, then tick-driven sequencing
    always_comb begin
        state_n  = state;
        dir_n    = active_dir;
        adv_n    = adv;
        load     = 1'b0;
        load_val = '0;
        if (!key[KEY_OFF]) begin
            state_n = F_OFF;
            load    = 1'b1;
        end else if (!key[KEY_YELLOW]) begin
            state_n = F_YELLOW;
            load    = 1'b1;
        end else if (!key[KEY_RED]) begin
            state_n = F_RED;
            load    = 1'b1;
        end else if (!key[KEY_GREEN]) begin
            state_n = F_GREEN;
            load    = 1'b1;
        end else if (forced) begin
            state_n  = S_ALL_RED;
            load     = 1'b1;
            load_val = CNT_W'(T_ALLRED);
            adv_n    = 1'b0;
        end else if (expire) begin
            load = 1'b1;
            case (state)
                S_GREEN: begin
                    state_n  = S_YELLOW;
                    load_val = CNT_W'(T_YELLOW);
                end
                S_YELLOW: begin
                    state_n  = S_ALL_RED;
                    load_val = CNT_W'(T_ALLRED);
                    adv_n    = 1'b1;
                end
                default: begin
                    state_n  = S_GREEN;
                    load_val = CNT_W'(T_GREEN);
                    adv_n    = 1'b0;
                    dir_n    = !adv ? active_dir : (active_dir == AW'(N_DIR - 1)) ? '0 : active_dir + AW'(1);
                end
            endcase
        end
    end

`ifdef TRAFFIC_FLASH_EN
    logic phase;
    // flash phase restarts lit on every F_YELLOW entry and toggles each second while held
    always_ff @(posedge clk) begin
        if (rst || (state_n == F_YELLOW && state != F_YELLOW)) phase <= 1'b0;
        else if (state == F_YELLOW && tick_1hz)                 phase <= ~phase;
    end
    assign yel_on = ~phase;
`else
    assign yel_on = 1'b1;
`endif

    // lamp and display decode from the registered state
    always_comb begin
        red       = '0;
        yellow    = '0;
        green     = '0;
        blank     = 1'b0;
        countdown = forced ? '0 : timer;
        case (state)
            S_GREEN, F_GREEN: begin
                green = dir_mask;
                red   = ~dir_mask;
            end
            S_YELLOW: begin
                yellow = dir_mask;
                red    = ~dir_mask;
            end
            F_YELLOW: yellow = {N_DIR{yel_on}};
            F_OFF:    blank  = 1'b1;
            default:  red    = '1;
        endcase
    end
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// tb_traffic_ctrl_multi: scoreboard bench against a behavioural model of the 3-approach controller
module tb_traffic_ctrl_multi;
    localparam int N = 3;
    localparam int TG = 30, TY = 5, TA = 2, TM = 8;

    typedef struct {
        logic [2:0] r, y, g;
        logic [1:0] d;
        logic [5:0] c;
        logic       b;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1, tick_1hz = 1'b0;
    logic [3:0] key = 4'hF;
    logic [2:0] ped_req = '0, red, yellow, green;
    logic [1:0] active_dir;
    logic [5:0] countdown;
    logic       blank;
    int         checks = 0, errors = 0;
    exp_t       q[$];

    // model: forced 0=none 1=green 2=red 3=yellow 4=off; phase 0=green 1=yellow 2=clearance
    int         m_forced, m_phase, m_dir, m_rem, m_from_y, m_flash;
    logic [2:0] m_pend;
    int         dur[3] = '{TG, TY, TA};

    traffic_ctrl_multi #(.N_DIR(N), .CNT_W(6), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_MIN_GREEN(TM)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .key(key), .ped_req(ped_req),
        .red(red), .yellow(yellow), .green(green), .active_dir(active_dir),
        .countdown(countdown), .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic model(input logic r, input logic t, input logic [3:0] k, input logic [2:0] p);
        logic [2:0] mask, newp;
        int fk;
        if (r) begin
            m_forced = 0; m_phase = 2; m_dir = 0; m_rem = TA; m_pend = '0; m_from_y = 0; m_flash = 0;
            return;
        end
        mask = 3'b001 << m_dir;
        newp = m_pend | (p & ~((m_forced == 0 && m_phase == 0) ? mask : 3'b000));
        if (k != 4'hF) begin
            fk = !k[3] ? 4 : !k[2] ? 3 : !k[1] ? 2 : 1;
            if (fk == 3 && m_forced != 3) m_flash = 0;
            else if (fk == 3 && t) m_flash ^= 1;
            m_forced = fk;
            m_rem = 0;
        end else if (m_forced != 0) begin
            m_forced = 0; m_phase = 2; m_rem = TA; m_from_y = 0;
        end else if (m_phase == 0 && (newp & ~mask) != 0 && m_rem > TM) begin
            m_rem = TM;
        end else if (t) begin
            if (m_rem <= 1) begin
                if (m_phase == 2) begin
                    if (m_from_y != 0) m_dir = (m_dir + 1) % N;
                    m_from_y = 0;
                    m_phase = 0;
                    newp[m_dir] = 1'b0;
                end else begin
                    m_from_y = (m_phase == 1) ? 1 : 0;
                    m_phase++;
                end
                m_rem = dur[m_phase];
            end else m_rem--;
        end
        m_pend = newp;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        logic [2:0] mask;
        mask = 3'b001 << m_dir;
        e.r = '0; e.y = '0; e.g = '0; e.b = 1'b0;
        e.d = 2'(m_dir);
        e.c = (m_forced != 0) ? 6'd0 : 6'(m_rem);
        if (m_forced == 4) e.b = 1'b1;
        else if (m_forced == 2 || (m_forced == 0 && m_phase == 2)) e.r = '1;
`ifdef TRAFFIC_FLASH_EN
        else if (m_forced == 3) e.y = (m_flash != 0) ? 3'b000 : 3'b111;
`else
        else if (m_forced == 3) e.y = 3'b111;
`endif
        else if (m_forced == 0 && m_phase == 1) begin e.y = mask; e.r = ~mask; end
        else begin e.g = mask; e.r = ~mask; end
        return e;
    endfunction

    task automatic cyc(input logic r, input logic t, input logic [3:0] k, input logic [2:0] p);
        @(negedge clk);
        rst = r; tick_1hz = t; key = k; ped_req = p;
        model(r, t, k, p);
        q.push_back(expect_now());
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // monitor: outputs are valid every cycle, compare one expectation per clock edge
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("red", int'(red), int'(e.r));
            chk("yellow", int'(yellow), int'(e.y));
            chk("green", int'(green), int'(e.g));
            chk("active_dir", int'(active_dir), int'(e.d));
            chk("countdown", int'(countdown), int'(e.c));
            chk("blank", int'(blank), int'(e.b));
        end
    end

    initial begin
        logic [3:0] kv;
        int hold;
        cyc(1, 0, 4'hF, 3'b000);
        for (int n = 0; n < 1200; n++)
            cyc(0, n % 10 == 9, 4'hF, (n == 120) ? 3'b010 : (n == 150) ? 3'b100 : 3'b000);
        for (int n = 0; n < 5; n++) cyc(0, n == 2, 4'b0110, 3'b000);
        for (int n = 0; n < 60; n++) cyc(0, n % 10 == 9, 4'hF, 3'b000);
        cyc(0, 1, 4'b1101, 3'b000);
        for (int n = 0; n < 3; n++) cyc(0, 0, 4'b1101, 3'b000);
        for (int n = 0; n < 30; n++) cyc(0, n % 10 == 9, 4'hF, 3'b000);
        for (int n = 0; n < 12; n++) cyc(0, n % 3 == 2, 4'b1011, 3'b001);
        for (int n = 0; n < 400; n++) cyc(0, n % 10 == 9, 4'hF, 3'b000);
        cyc(1, 1, 4'hF, 3'b111);
        hold = 0;
        kv = 4'hF;
        for (int n = 0; n < 2500; n++) begin
            if (hold == 0) begin
                kv = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
                hold = $urandom_range(1, 40);
            end
            hold--;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, kv,
                ($urandom_range(0, 29) == 0) ? 3'($urandom) : 3'b000);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
